// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the fetch/decode instruction queue.
package if_id_queue_pkg;

    localparam int DATA_WIDTH = 32;

    // addi x0,x0,0 -- what decode sees whenever the queue presents nothing
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instruction;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pc_plus4;
    } if_id_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_PARTIAL,
        OCC_FULL
    } occ_t;

    function automatic occ_t occ_of(input int cnt, input int depth);
        occ_t occ;
        if (cnt == 0) begin
            occ = OCC_EMPTY;
        end else if (cnt >= depth) begin
            occ = OCC_FULL;
        end else begin
            occ = OCC_PARTIAL;
        end
        return occ;
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle; master drives the fetch side and decode ready, slave is the queue.
interface if_id_queue_if
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2
);
    logic                       IF_valid_i;
    logic                       IF_ready_o;
    logic [DATA_WIDTH-1:0]      IF_instruction_i;
    logic [DATA_WIDTH-1:0]      IF_pc_i;
    logic [DATA_WIDTH-1:0]      IF_pc_plus4_i;
    logic                       IF_flush_i;
    logic                       ID_valid_o;
    logic                       ID_ready_i;
    logic [DATA_WIDTH-1:0]      ID_instruction_o;
    logic [DATA_WIDTH-1:0]      ID_pc_o;
    logic [DATA_WIDTH-1:0]      ID_pc_plus4_o;
    logic [$clog2(DEPTH+1)-1:0] ID_count_o;

    modport master (
        output IF_valid_i, IF_instruction_i, IF_pc_i, IF_pc_plus4_i, IF_flush_i, ID_ready_i,
        input  IF_ready_o, ID_valid_o, ID_instruction_o, ID_pc_o, ID_pc_plus4_o, ID_count_o
    );

    modport slave (
        input  IF_valid_i, IF_instruction_i, IF_pc_i, IF_pc_plus4_i, IF_flush_i, ID_ready_i,
        output IF_ready_o, ID_valid_o, ID_instruction_o, ID_pc_o, ID_pc_plus4_o, ID_count_o
    );

endinterface

// File: rtl/if_id_queue_mem.sv
// Entry storage for the instruction queue: one write port, one asynchronous read port, no reset.
module if_id_queue_mem
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  if_id_entry_t      wdata,
    input  logic [ADDR_W-1:0] raddr,
    output if_id_entry_t      rdata
);

    if_id_entry_t mem [DEPTH];

    // Contents are meaningful only below the occupancy count held by the owner
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue with flush on redirect.
// Optional 0-cycle empty-queue bypass enabled by defining IF_ID_QUEUE_BYPASS_EN.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    if_id_queue_if.slave q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    occ_t             occ;
    logic             ready;
    logic             flush;
    logic             push;
    logic             pop;
    logic             out_valid;
    if_id_entry_t     wr_entry;
    if_id_entry_t     head_entry;
    if_id_entry_t     out_entry;

    assign occ      = occ_of(int'(count), DEPTH);
    assign flush    = q.IF_flush_i;
    assign wr_entry = '{instruction: q.IF_instruction_i,
                        pc:          q.IF_pc_i,
                        pc_plus4:    q.IF_pc_plus4_i};

    // Ready looks only at registered occupancy, so a pop never opens a full queue in the same cycle
    assign ready = (occ != OCC_FULL);

`ifdef IF_ID_QUEUE_BYPASS_EN
    logic bypass;

    always_comb begin
        bypass    = (occ == OCC_EMPTY) && !flush && q.IF_valid_i;
        out_valid = !flush && ((occ != OCC_EMPTY) || q.IF_valid_i);
        out_entry = (occ == OCC_EMPTY) ? wr_entry : head_entry;
        // A bypassed triple taken by decode this cycle never lands in storage
        push      = q.IF_valid_i && ready && !flush && !(bypass && q.ID_ready_i);
        pop       = !flush && (occ != OCC_EMPTY) && q.ID_ready_i;
    end
`else
    always_comb begin
        out_valid = !flush && (occ != OCC_EMPTY);
        out_entry = head_entry;
        push      = q.IF_valid_i && ready && !flush;
        pop       = out_valid && q.ID_ready_i;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    if_id_queue_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head_entry)
    );

    // Storage is never reset, so data outputs are gated by valid
    always_comb begin
        q.ID_instruction_o = NOP_INSTR;
        q.ID_pc_o          = '0;
        q.ID_pc_plus4_o    = '0;
        if (out_valid) begin
            q.ID_instruction_o = out_entry.instruction;
            q.ID_pc_o          = out_entry.pc;
            q.ID_pc_plus4_o    = out_entry.pc_plus4;
        end
    end

    assign q.IF_ready_o = ready;
    assign q.ID_valid_o = out_valid;
    assign q.ID_count_o = count;

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Decoupling instruction queue between the fetch stage and the decode stage of the RISC-V pipeline. It captures the {instruction, pc, pc+4} triple produced by fetch each cycle and presents it to decode through a valid/ready handshake. It absorbs decode stalls without losing fetched instructions. It drops all queued entries when a taken branch redirects the PC.

## Interface
Parameters:
- DEPTH, 2, number of entries; power of two, ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IF_valid_i  in  1  fetch presents a valid triple.
- IF_ready_o  out  1  queue can accept this cycle; equals !full.
- IF_instruction_i  in  DATA_WIDTH  fetched instruction.
- IF_pc_i  in  DATA_WIDTH  PC of the instruction.
- IF_pc_plus4_i  in  DATA_WIDTH  PC+4.
- IF_flush_i  in  1  redirect (PCSrc taken); discard all contents.
- ID_valid_o  out  1  head entry valid for decode.
- ID_ready_i  in  1  decode accepts the head this cycle.
- ID_instruction_o  out  DATA_WIDTH  head instruction; NOP_INSTR when !ID_valid_o.
- ID_pc_o  out  DATA_WIDTH  head PC; 0 when !ID_valid_o.
- ID_pc_plus4_o  out  DATA_WIDTH  head PC+4; 0 when !ID_valid_o.
- ID_count_o  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Circular buffer with wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH) and a count register.
- Occupancy states are derived from count, not encoded separately: EMPTY (0), PARTIAL, FULL (DEPTH).
- Push when IF_valid_i && IF_ready_o: write the entry at wr_ptr, then increment wr_ptr.
- Pop when ID_valid_o && ID_ready_i: increment rd_ptr.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- FULL: IF_ready_o=0. A pop in the same cycle does not make the queue ready in that same cycle (no ready-through path).
- EMPTY: ID_valid_o=0 and the data outputs show NOP_INSTR/0/0.
- Flush takes priority over push and pop:
  - count, wr_ptr and rd_ptr clear to 0 on the next edge.
  - IF_valid_i in the flush cycle is ignored.
  - ID_valid_o is forced 0 combinationally during the flush cycle.
  - Storage contents are don't-care.
- Asynchronous reset, including mid-operation: pointers and count go to 0, ID_valid_o=0, IF_ready_o=1, and the data outputs read NOP_INSTR/0/0.

## Timing
- Without bypass, latency is 1 cycle: a triple pushed at edge N is presented with ID_valid_o=1 after edge N.
- ID_* outputs are a combinational read of the head entry, gated by valid.
- IF_ready_o depends only on registered count, with no combinational path from ID_ready_i.
- Throughput is 1 entry per cycle with DEPTH ≥ 2 while decode is ready.
- ID_count_o is registered.

## Configuration
- Macro: IF_ID_QUEUE_BYPASS_EN.
- Defined:
  - When the queue is EMPTY and IF_flush_i=0, ID_valid_o follows IF_valid_i and ID_* follow IF_* combinationally, giving 0-cycle latency.
  - If ID_ready_i=1 in that cycle, the triple is consumed and not written.
  - Otherwise it is written normally.
- Undefined: the behaviour is exactly as in Operation/Timing, with no IF→ID combinational path.

## Structure
- Package defines holds:
  - DATA_WIDTH (existing).
  - NOP_INSTR = 32'h0000_0013 (addi x0,x0,0).
  - if_id_entry_t, a packed struct {instruction, pc, pc_plus4}.
- Sub-module if_id_queue_mem: a DEPTH × if_id_entry_t register array with one write port and one asynchronous read port. It has no reset; validity is tracked only by count.
- Pointer and count logic stays in if_id_queue.

## Test plan
- Reset, then push a single entry: 0x00500093 at PC 0x0, with ID_ready_i=1 → ID_valid_o=1 one cycle later with pc=0x0 and pc_plus4=0x4; queue then empty with NOP_INSTR on output.
- Hold ID_ready_i=0 and push 0x00500093 then 0x00600113 at PC 0x0/0x4 (DEPTH=2) → IF_ready_o=0 and ID_count_o=2; raise ID_ready_i → entries emerge in order PC 0x0 then 0x4, and IF_ready_o returns to 1.
- Stream 8 pushes at PC 0x0–0x1C with ID_ready_i=1 → 8 pops in order with the pointers wrapping 4 times, no bubbles after the first, and ID_count_o stable at 1.
- Queue holding 2 entries, then IF_flush_i=1 together with IF_valid_i=1 at PC 0x40 → ID_valid_o=0 in that cycle; next cycle count=0 and PC 0x40 has not been enqueued.
- Assert rst_n=0 asynchronously mid-clock with count=1 → ID_valid_o=0, ID_count_o=0 and IF_ready_o=1 immediately, without waiting for a clock edge.
- With IF_ID_QUEUE_BYPASS_EN defined, empty queue, IF_valid_i=1 and ID_ready_i=1 at PC 0x8 → ID_valid_o=1 with ID_pc_o=0x8 in the same cycle, and count stays 0.
